regfile_wr_arbiter: RTL and testbench

- Shares the two regfile write ports (writeReg1/writeData1, writeReg2/writeData2, single `write` strobe) among NREQ write requesters.
- Uses a valid/ready handshake per requester.
- Round-robin grants up to two distinct-address writes per cycle.
- A clear sequencer zeroes all registers on command.
- Sits between the execute/writeback units and `regfile`; its rf_* outputs connect directly to the regfile write inputs.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/wr_rr_picker.sv | 35 +++
 rtl/regfile_wr_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the regfile write arbiter.
package regfile_pkg;

    localparam int unsigned RF_DATAWIDTH = 32;
    localparam int unsigned RF_ADDRWIDTH = 4;
    localparam int unsigned RF_NREGS     = 16;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } wr_arb_state_t;

    typedef logic [RF_ADDRWIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATAWIDTH-1:0] rf_data_t;

endpackage

// File: rtl/wr_rr_picker.sv
// Round-robin first-eligible picker: scans from rr_ptr_i upward (mod NREQ) and
// returns the first requester that is valid and not excluded.
module wr_rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PTRW = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PTRW-1:0] rr_ptr_i,
    input  logic [NREQ-1:0] excl_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [PTRW-1:0] idx_o,
    output logic            found_o
);

    logic [NREQ-1:0] elig;

    assign elig = valid_i & ~excl_i;

    always_comb begin
        int unsigned pos;
        pos      = 0;
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = (32'(rr_ptr_i) + k) % NREQ;
            if (!found_o && elig[PTRW'(pos)]) begin
                found_o                = 1'b1;
                onehot_o[PTRW'(pos)]   = 1'b1;
                idx_o                  = PTRW'(pos);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates NREQ write requesters onto the two regfile write ports and runs a
// zeroing sweep on clear_start. Optional per-requester grant counters are built
// when REGFILE_WR_ARB_STATS_EN is defined.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DATAWIDTH = RF_DATAWIDTH,
    parameter int unsigned ADDRWIDTH = RF_ADDRWIDTH,
    parameter int unsigned NREGS     = RF_NREGS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      rf_write,
    output logic [ADDRWIDTH-1:0]      rf_writeReg1,
    output logic [DATAWIDTH-1:0]      rf_writeData1,
    output logic [ADDRWIDTH-1:0]      rf_writeReg2,
    output logic [DATAWIDTH-1:0]      rf_writeData2
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]        grant_count
`endif
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IDXW = (NREGS > 2) ? $clog2(NREGS / 2) : 1;
    localparam logic [PTRW-1:0] LAST_REQ = PTRW'(NREQ - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS / 2 - 1);

    wr_arb_state_t        state_q, state_d;
    logic [PTRW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic                 rf_write_q, rf_write_d;
    logic [ADDRWIDTH-1:0] rf_reg1_q, rf_reg1_d;
    logic [ADDRWIDTH-1:0] rf_reg2_q, rf_reg2_d;
    logic [DATAWIDTH-1:0] rf_data1_q, rf_data1_d;
    logic [DATAWIDTH-1:0] rf_data2_q, rf_data2_d;
    logic                 clear_busy_q, clear_busy_d;
    logic                 clear_done_q, clear_done_d;

    logic [ADDRWIDTH-1:0] addr [NREQ];
    logic [DATAWIDTH-1:0] data [NREQ];
    logic [NREQ-1:0]      arb_valid;
    logic [NREQ-1:0]      addr_match;
    logic [NREQ-1:0]      gnt_a, gnt_b;
    logic [PTRW-1:0]      idx_a, idx_b, last_idx;
    logic                 found_a, found_b;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr[g] = req_addr[g*ADDRWIDTH +: ADDRWIDTH];
        assign data[g] = req_data[g*DATAWIDTH +: DATAWIDTH];
    end

    // Grants only happen in ARB when no clear is being requested.
    assign arb_valid = (!reset && state_q == ARB && !clear_start) ? req_valid : '0;

    wr_rr_picker #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick_a (
        .valid_i  (arb_valid),
        .rr_ptr_i (rr_ptr_q),
        .excl_i   ({NREQ{1'b0}}),
        .onehot_o (gnt_a),
        .idx_o    (idx_a),
        .found_o  (found_a)
    );

    // Slot B excludes every requester aimed at slot A's address, including A itself.
    always_comb begin
        addr_match = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_match[i] = (addr[i] == addr[idx_a]);
        end
    end

    wr_rr_picker #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick_b (
        .valid_i  (arb_valid),
        .rr_ptr_i (rr_ptr_q),
        .excl_i   (addr_match),
        .onehot_o (gnt_b),
        .idx_o    (idx_b),
        .found_o  (found_b)
    );

    assign req_ready = found_a ? (gnt_a | (found_b ? gnt_b : '0)) : '0;
    assign last_idx  = found_b ? idx_b : idx_a;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        idx_d        = idx_q;
        rf_write_d   = 1'b0;
        rf_reg1_d    = rf_reg1_q;
        rf_reg2_d    = rf_reg2_q;
        rf_data1_d   = rf_data1_q;
        rf_data2_d   = rf_data2_q;
        clear_busy_d = 1'b0;
        clear_done_d = 1'b0;
        unique case (state_q)
            ARB: begin
                if (clear_start) begin
                    state_d      = CLEAR;
                    idx_d        = '0;
                    clear_busy_d = 1'b1;
                end else if (found_a) begin
                    rf_write_d = 1'b1;
                    rf_reg1_d  = addr[idx_a];
                    rf_data1_d = data[idx_a];
                    // The write strobe is shared, so a lone grant is mirrored on port 2.
                    rf_reg2_d  = found_b ? addr[idx_b] : addr[idx_a];
                    rf_data2_d = found_b ? data[idx_b] : data[idx_a];
                    rr_ptr_d   = (last_idx == LAST_REQ) ? '0 : last_idx + PTRW'(1);
                end
            end
            CLEAR: begin
                rf_write_d   = 1'b1;
                rf_reg1_d    = ADDRWIDTH'({idx_q, 1'b0});
                rf_reg2_d    = ADDRWIDTH'({idx_q, 1'b1});
                rf_data1_d   = '0;
                rf_data2_d   = '0;
                clear_busy_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d      = ARB;
                    idx_d        = '0;
                    clear_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB;
            rr_ptr_q     <= '0;
            idx_q        <= '0;
            rf_write_q   <= 1'b0;
            rf_reg1_q    <= '0;
            rf_reg2_q    <= '0;
            rf_data1_q   <= '0;
            rf_data2_q   <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            idx_q        <= idx_d;
            rf_write_q   <= rf_write_d;
            rf_reg1_q    <= rf_reg1_d;
            rf_reg2_q    <= rf_reg2_d;
            rf_data1_q   <= rf_data1_d;
            rf_data2_q   <= rf_data2_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign rf_write      = rf_write_q;
    assign rf_writeReg1  = rf_reg1_q;
    assign rf_writeReg2  = rf_reg2_q;
    assign rf_writeData1 = rf_data1_q;
    assign rf_writeData2 = rf_data2_q;
    assign clear_busy    = clear_busy_q;
    assign clear_done    = clear_done_q;

`ifdef REGFILE_WR_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] cnt_d [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_valid[i] && req_ready[i] && cnt_q[i] != 16'hFFFF) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign grant_count[g*16 +: 16] = cnt_q[g];
    end
`else
    // No grant statistics in this build.
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural regfile on the rf_* outputs.
module tb_regfile_wr_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [15:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         clear_start;
    logic         clear_busy;
    logic         clear_done;
    logic         rf_write;
    logic [3:0]   rf_writeReg1;
    logic [31:0]  rf_writeData1;
    logic [3:0]   rf_writeReg2;
    logic [31:0]  rf_writeData2;
`ifdef REGFILE_WR_ARB_STATS_EN
    logic [63:0]  grant_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mem [16];

    regfile_wr_arbiter #(
        .NREQ      (4),
        .DATAWIDTH (32),
        .ADDRWIDTH (4),
        .NREGS     (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .clear_start   (clear_start),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .rf_write      (rf_write),
        .rf_writeReg1  (rf_writeReg1),
        .rf_writeData1 (rf_writeData1),
        .rf_writeReg2  (rf_writeReg2),
        .rf_writeData2 (rf_writeData2)
`ifdef REGFILE_WR_ARB_STATS_EN
        ,
        .grant_count   (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_write) begin
            mem[rf_writeReg1] <= rf_writeData1;
            mem[rf_writeReg2] <= rf_writeData2;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
        req_addr[i*4 +: 4]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    // Entered at a negedge; checks ready, drops accepted valids, returns at next negedge.
    task automatic accept_cycle(input string tag, input logic [3:0] exp_ready);
        logic [3:0] took;
        #1;
        check_eq(tag, {60'd0, req_ready}, {60'd0, exp_ready});
        took = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~took;
        @(negedge clk);
    endtask

    task automatic check_rf(input string tag, input logic w, input logic [3:0] a1,
                            input logic [31:0] d1, input logic [3:0] a2, input logic [31:0] d2);
        check_eq({tag, "_wr"}, {63'd0, rf_write}, {63'd0, w});
        check_eq({tag, "_a1"}, {60'd0, rf_writeReg1}, {60'd0, a1});
        check_eq({tag, "_d1"}, {32'd0, rf_writeData1}, {32'd0, d1});
        check_eq({tag, "_a2"}, {60'd0, rf_writeReg2}, {60'd0, a2});
        check_eq({tag, "_d2"}, {32'd0, rf_writeData2}, {32'd0, d2});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        clear_start = 1'b0;

        // Reset state, with a request pending to show ready is masked during reset.
        set_req(1, 4'd3, 32'hAAAAAAAA);
        req_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_rf("rst", 1'b0, 4'd0, 32'd0, 4'd0, 32'd0);
        check_eq("rst_busy", {63'd0, clear_busy}, 64'd0);
        check_eq("rst_done", {63'd0, clear_done}, 64'd0);
        check_eq("rst_ready", {60'd0, req_ready}, 64'd0);

        // Single requester 1 -> R3, mirrored on port 2.
        @(negedge clk);
        reset = 1'b0;
        accept_cycle("t1_ready", 4'b0010);
        check_rf("t1_rf", 1'b1, 4'd3, 32'hAAAAAAAA, 4'd3, 32'hAAAAAAAA);
        @(negedge clk);
        check_rf("t1_hold", 1'b0, 4'd3, 32'hAAAAAAAA, 4'd3, 32'hAAAAAAAA);
        check_eq("t1_mem3", {32'd0, mem[3]}, 64'hAAAAAAAA);

        // Four distinct addresses from rr_ptr=0.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 32'h11111111 * (i + 1));
        req_valid = 4'b1111;
        accept_cycle("t2_ready0", 4'b0011);
        check_rf("t2_rf0", 1'b1, 4'd1, 32'h11111111, 4'd2, 32'h22222222);
        accept_cycle("t2_ready1", 4'b1100);
        check_rf("t2_rf1", 1'b1, 4'd3, 32'h33333333, 4'd4, 32'h44444444);
        @(negedge clk);
        for (int i = 1; i <= 4; i++) check_eq("t2_mem", {32'd0, mem[i]}, 64'h11111111 * i);

        // Same-address conflict; rr_ptr should be back at 0 here.
        set_req(0, 4'd5, 32'hDEADBEEF);
        set_req(2, 4'd5, 32'hFACECAFE);
        set_req(3, 4'd6, 32'h12345678);
        req_valid = 4'b1101;
        accept_cycle("t3_ready0", 4'b1001);
        check_rf("t3_rf0", 1'b1, 4'd5, 32'hDEADBEEF, 4'd6, 32'h12345678);
        accept_cycle("t3_ready1", 4'b0100);
        check_rf("t3_rf1", 1'b1, 4'd5, 32'hFACECAFE, 4'd5, 32'hFACECAFE);
        @(negedge clk);
        check_eq("t3_mem5", {32'd0, mem[5]}, 64'hFACECAFE);
        check_eq("t3_mem6", {32'd0, mem[6]}, 64'h12345678);

        // Clear sweep; clear wins over a same-cycle request, restart during sweep is ignored.
        set_req(0, 4'd7, 32'h00000077);
        req_valid   = 4'b0001;
        clear_start = 1'b1;
        #1;
        check_eq("clr_c_ready", {60'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) clear_start = 1'b1;
            if (k == 4) clear_start = 1'b0;
            #1;
            check_eq("clr_busy", {63'd0, clear_busy}, {63'd0, (k <= 9)});
            check_eq("clr_done", {63'd0, clear_done}, {63'd0, (k == 9)});
            if (k == 1) check_eq("clr_wr1", {63'd0, rf_write}, 64'd0);
            if (k >= 2 && k <= 9) begin
                check_rf("clr_pair", 1'b1, 4'(2 * (k - 2)), 32'd0, 4'(2 * (k - 2) + 1), 32'd0);
            end
            if (k <= 8) check_eq("clr_ready", {60'd0, req_ready}, 64'd0);
            if (k == 9) begin
                check_eq("clr_ready9", {60'd0, req_ready}, 64'd1);
                @(posedge clk);
                #1;
                req_valid = '0;
            end
            if (k == 10) check_rf("clr_after", 1'b1, 4'd7, 32'h77, 4'd7, 32'h77);
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check_eq("clr_mem", {32'd0, mem[i]}, (i == 7) ? 64'h77 : 64'd0);
        end

        // Reset during the third CLEAR cycle aborts the sweep.
        set_req(0, 4'd0, 32'h000000A0);
        set_req(1, 4'd4, 32'h44444444);
        req_valid = 4'b0011;
        accept_cycle("t5_ready", 4'b0011);
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_rf("t5_rst", 1'b0, 4'd0, 32'd0, 4'd0, 32'd0);
        check_eq("t5_busy", {63'd0, clear_busy}, 64'd0);
        check_eq("t5_done", {63'd0, clear_done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5_done2", {63'd0, clear_done}, 64'd0);
        check_eq("t5_wr2", {63'd0, rf_write}, 64'd0);
        for (int i = 0; i < 4; i++) check_eq("t5_mem", {32'd0, mem[i]}, 64'd0);
        check_eq("t5_mem4", {32'd0, mem[4]}, 64'h44444444);
        for (int i = 0; i < 4; i++) set_req(i, 4'(8 + i), 32'hB0 + i);
        req_valid = 4'b1111;
        accept_cycle("t5_arb0", 4'b0011);
        check_rf("t5_rf0", 1'b1, 4'd8, 32'hB0, 4'd9, 32'hB1);
        accept_cycle("t5_arb1", 4'b1100);
        @(negedge clk);

`ifdef REGFILE_WR_ARB_STATS_EN
        do_reset();
        for (int n = 0; n < 5; n++) begin
            set_req(0, 4'd1, 32'(n));
            req_valid = 4'b0001;
            accept_cycle("st_ready", 4'b0001);
        end
        @(negedge clk);
        check_eq("st_cnt0", {48'd0, grant_count[15:0]}, 64'd5);
        check_eq("st_rest", {16'd0, grant_count[63:16]}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
